// File: rtl/riscv_imm_pkg.sv
// Immediate-format codes, range bounds and a field extractor shared by the
// immediate extender, the control decoder and the immediate encoder.
package riscv_imm_pkg;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // Signed bounds of the representable immediate per format
  localparam logic signed [31:0] IMM12_MIN = -32'sd2048;
  localparam logic signed [31:0] IMM12_MAX =  32'sd2047;
  localparam logic signed [31:0] IMM13_MIN = -32'sd4096;
  localparam logic signed [31:0] IMM13_MAX =  32'sd4095;
  localparam logic signed [31:0] IMM21_MIN = -32'sd1048576;
  localparam logic signed [31:0] IMM21_MAX =  32'sd1048575;

  typedef struct packed {
    logic [2:0]  immsrc;
    logic [31:0] imm;
    logic [31:0] tmpl;
  } imm_req_t;

  // Same extraction the extender performs; used to cross-check the packer.
  function automatic logic [31:0] extract_imm(input logic [2:0] src, input logic [31:0] i);
    case (src)
      IMM_I:   extract_imm = {{20{i[31]}}, i[31:20]};
      IMM_S:   extract_imm = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   extract_imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_J:   extract_imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      IMM_U:   extract_imm = {i[31:12], 12'b0};
      default: extract_imm = '0;
    endcase
  endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// Request/response handshake bundle of the immediate encoder.
interface imm_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_immsrc;
  logic [31:0] in_imm;
  logic [31:0] in_tmpl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;

  modport master (
    output in_valid, in_immsrc, in_imm, in_tmpl, out_ready,
    input  in_ready, out_valid, out_instr, out_err
  );

  modport slave (
    input  in_valid, in_immsrc, in_imm, in_tmpl, out_ready,
    output in_ready, out_valid, out_instr, out_err
  );
endinterface

// File: rtl/imm_pack.sv
// Combinational packer: scatters an immediate into its format's instruction
// bit positions over a template and flags unrepresentable values.
module imm_pack
  import riscv_imm_pkg::*;
(
  input  logic [2:0]  immsrc_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] tmpl_i,
  output logic [31:0] instr_o,
  output logic        err_o
);

  logic signed [31:0] simm;
  assign simm = $signed(imm_i);

  always_comb begin
    instr_o = tmpl_i;
    err_o   = 1'b0;
    case (immsrc_i)
      IMM_I: begin
        instr_o[31:20] = imm_i[11:0];
        err_o          = (simm < IMM12_MIN) || (simm > IMM12_MAX);
      end
      IMM_S: begin
        instr_o[31:25] = imm_i[11:5];
        instr_o[11:7]  = imm_i[4:0];
        err_o          = (simm < IMM12_MIN) || (simm > IMM12_MAX);
      end
      IMM_B: begin
        instr_o[31]    = imm_i[12];
        instr_o[7]     = imm_i[11];
        instr_o[30:25] = imm_i[10:5];
        instr_o[11:8]  = imm_i[4:1];
        err_o          = (simm < IMM13_MIN) || (simm > IMM13_MAX) || imm_i[0];
      end
      IMM_J: begin
        instr_o[31]    = imm_i[20];
        instr_o[30:21] = imm_i[10:1];
        instr_o[20]    = imm_i[11];
        instr_o[19:12] = imm_i[19:12];
        err_o          = (simm < IMM21_MIN) || (simm > IMM21_MAX) || imm_i[0];
      end
      IMM_U: begin
        instr_o[31:12] = imm_i[31:12];
        err_o          = |imm_i[11:0];
      end
      // Unknown format: template passes through untouched, flagged as error
      default: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage valid/ready immediate encoder with saturating statistics.
// Define IMM_ENCODER_SELFCHECK_EN to add the re-extraction cross-check port.
module imm_encoder
  import riscv_imm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  imm_encoder_if.slave     bus,
`ifdef IMM_ENCODER_SELFCHECK_EN
  output logic             chk_mismatch,
`endif
  output logic [CNT_W-1:0] enc_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  imm_req_t         req_d, s1_req_q;
  logic             s1_vld_q, s2_vld_q;
  logic             s1_load, s2_load, accept, out_xfer;
  logic [31:0]      pack_instr, instr_q;
  logic             pack_err, err_q;
  logic [CNT_W-1:0] enc_cnt_d, enc_cnt_q, err_cnt_d, err_cnt_q;

  assign req_d = '{immsrc: bus.in_immsrc, imm: bus.in_imm, tmpl: bus.in_tmpl};

  // in_ready is combinational from out_ready so a full pipe streams at rate
  assign s2_load      = !s2_vld_q || bus.out_ready;
  assign s1_load      = !s1_vld_q || s2_load;
  assign accept       = bus.in_valid && s1_load;
  assign out_xfer     = s2_vld_q && bus.out_ready;
  assign bus.in_ready = s1_load;

  imm_pack u_pack (
    .immsrc_i (s1_req_q.immsrc),
    .imm_i    (s1_req_q.imm),
    .tmpl_i   (s1_req_q.tmpl),
    .instr_o  (pack_instr),
    .err_o    (pack_err)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld_q <= 1'b0;
      s1_req_q <= '0;
    end else if (s1_load) begin
      s1_vld_q <= bus.in_valid;
      if (accept) s1_req_q <= req_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_vld_q <= 1'b0;
      instr_q  <= '0;
      err_q    <= 1'b0;
    end else if (s2_load) begin
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        instr_q <= pack_instr;
        err_q   <= pack_err;
      end
    end
  end

  always_comb begin
    enc_cnt_d = enc_cnt_q;
    err_cnt_d = err_cnt_q;
    if (out_xfer) begin
      if (err_q) begin
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
      end else begin
        if (enc_cnt_q != '1) enc_cnt_d = enc_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enc_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      enc_cnt_q <= enc_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.out_valid = s2_vld_q;
  assign bus.out_instr = instr_q;
  assign bus.out_err   = err_q;
  assign enc_cnt       = enc_cnt_q;
  assign err_cnt       = err_cnt_q;

`ifdef IMM_ENCODER_SELFCHECK_EN
  logic [31:0] s2_imm_q;
  logic [2:0]  s2_src_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_imm_q <= '0;
      s2_src_q <= '0;
    end else if (s2_load && s1_vld_q) begin
      s2_imm_q <= s1_req_q.imm;
      s2_src_q <= s1_req_q.immsrc;
    end
  end

  // A clean word must decode back to exactly the immediate that was packed
  assign chk_mismatch = s2_vld_q && !err_q && (extract_imm(s2_src_q, instr_q) != s2_imm_q);

  a_no_mismatch: assert property (@(posedge clk) disable iff (reset) !chk_mismatch);
`endif

endmodule
